// File: rtl/i2s_master_pkg.sv
// Shared audio definitions for the I2S master and its clock generator.
// Holds the sample width, the default slot length and bit-clock divider,
// the run/idle state type and a helper that maps a frame bit index onto
// its position inside the current channel slot.
package i2s_master_pkg;

    localparam int unsigned SAMPLE_BITS   = 16;
    localparam int unsigned DEF_SLOT_BITS = 32;
    localparam int unsigned DEF_SCLK_DIV  = 2;

    typedef enum logic {StIdle, StRun} state_e;

    // Position of frame bit b within its slot (b mod slot_bits for b < 2*slot_bits).
    function automatic int unsigned slot_pos(input int unsigned b, input int unsigned slot_bits);
        return (b >= slot_bits) ? b - slot_bits : b;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock and word-select generator for the I2S master.
// Ports:
//   clk_i, rst_ni  system clock, asynchronous active-low reset
//   en_i           run enable (sampled on start and at frame boundaries)
//   start_o        idle-to-run edge strobe
//   fall_o/rise_o  strobes for the CLK edge that lowers/raises SCLK
//   wrap_o         falling edge where the frame wraps and keeps running
//   stop_o         falling edge where the frame wraps into idle
//   b_o, b_next_o  current frame bit index and its value after the next fall
//   sclk_o, lrclk_o bit clock and word select
module i2s_clkgen
    import i2s_master_pkg::*;
#(
    parameter int unsigned SCLK_DIV  = DEF_SCLK_DIV,
    parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
    localparam int unsigned BW = $clog2(2 * SLOT_BITS),
    localparam int unsigned DW = $clog2(SCLK_DIV)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic          start_o,
    output logic          fall_o,
    output logic          rise_o,
    output logic          wrap_o,
    output logic          stop_o,
    output logic [BW-1:0] b_o,
    output logic [BW-1:0] b_next_o,
    output logic          sclk_o,
    output logic          lrclk_o
);

    localparam logic [DW-1:0] DLast = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BLast = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] BSlot = BW'(SLOT_BITS);

    state_e        state_q, state_d;
    logic [DW-1:0] d_q, d_d;
    logic [BW-1:0] b_q, b_d, b_inc;
    logic          sclk_q, sclk_d;
    logic          lrclk_q, lrclk_d;
    logic          tick, last_b;

    always_comb begin
        tick    = (state_q == StRun) && (d_q == DLast);
        last_b  = (b_q == BLast);
        b_inc   = last_b ? '0 : b_q + BW'(1);
        start_o = (state_q == StIdle) && en_i;
        fall_o  = tick && sclk_q;
        rise_o  = tick && !sclk_q;
        stop_o  = fall_o && last_b && !en_i;
        wrap_o  = fall_o && last_b && en_i;

        state_d = state_q;
        d_d     = d_q;
        b_d     = b_q;
        sclk_d  = sclk_q;
        lrclk_d = lrclk_q;

        if (start_o) begin
            state_d = StRun;
            d_d     = '0;
            b_d     = '0;
            sclk_d  = 1'b0;
            lrclk_d = 1'b0;
        end else if (state_q == StRun) begin
            d_d = tick ? '0 : d_q + DW'(1);
            if (rise_o) begin
                sclk_d = 1'b1;
            end
            if (fall_o) begin
                sclk_d = 1'b0;
                if (stop_o) begin
                    // Frame boundary with EN low: park everything at zero.
                    state_d = StIdle;
                    b_d     = '0;
                    lrclk_d = 1'b0;
                end else begin
                    b_d     = b_inc;
                    lrclk_d = (b_inc >= BSlot);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            d_q     <= '0;
            b_q     <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            b_q     <= b_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign b_o      = b_q;
    assign b_next_o = b_inc;
    assign sclk_o   = sclk_q;
    assign lrclk_o  = lrclk_q;

endmodule

// File: rtl/i2s_master.sv
// I2S master transceiver: owns SCLK/LRCLK, serialises a 16-bit stereo pair
// to the DAC and deserialises the ADC stream into a stereo pair.
// Ports:
//   CLK, RESET_N   system clock, asynchronous active-low reset
//   EN             run enable
//   IN_L, IN_R     samples to transmit (latched at frame start)
//   OUT_L, OUT_R   last received pair, registered
//   i2s_sampled    one-CLK pulse when OUT_L/OUT_R update
//   i2s_sclk, i2s_lrclk, i2s_din  I2S outputs to the codec
//   i2s_dout       serial data from the ADC
module i2s_master
    import i2s_master_pkg::*;
#(
    parameter int unsigned SCLK_DIV  = DEF_SCLK_DIV,
    parameter int unsigned SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   EN,
    input  logic [SAMPLE_BITS-1:0] IN_L,
    input  logic [SAMPLE_BITS-1:0] IN_R,
    output logic [SAMPLE_BITS-1:0] OUT_L,
    output logic [SAMPLE_BITS-1:0] OUT_R,
    output logic                   i2s_sampled,
    output logic                   i2s_sclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_din,
    input  logic                   i2s_dout
);

    localparam int unsigned BW = $clog2(2 * SLOT_BITS);
    localparam int unsigned IW = $clog2(SAMPLE_BITS);

    logic          start, fall, rise, wrap, stop, lrclk;
    logic [BW-1:0] b, b_next;

    logic [SAMPLE_BITS-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [SAMPLE_BITS-1:0] rx_q, rx_d, hold_q, hold_d;
    logic [SAMPLE_BITS-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic [SAMPLE_BITS-1:0] tx_word;
    logic                   din_q, din_d, dout_q, sampled_q, sampled_d;
    logic [IW-1:0]          tx_idx;
    int unsigned            p_fall, p_rise;

    i2s_clkgen #(
        .SCLK_DIV (SCLK_DIV),
        .SLOT_BITS(SLOT_BITS)
    ) u_clkgen (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .en_i    (EN),
        .start_o (start),
        .fall_o  (fall),
        .rise_o  (rise),
        .wrap_o  (wrap),
        .stop_o  (stop),
        .b_o     (b),
        .b_next_o(b_next),
        .sclk_o  (i2s_sclk),
        .lrclk_o (lrclk)
    );

    always_comb begin
        // Transmit looks at the bit being entered; receive at the bit in progress.
        p_fall  = slot_pos(32'(b_next), SLOT_BITS);
        p_rise  = slot_pos(32'(b), SLOT_BITS);
        tx_word = (32'(b_next) >= SLOT_BITS) ? tx_r_q : tx_l_q;
        tx_idx  = IW'(SAMPLE_BITS - p_fall);

        tx_l_d    = tx_l_q;
        tx_r_d    = tx_r_q;
        din_d     = din_q;
        rx_d      = rx_q;
        hold_d    = hold_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        sampled_d = 1'b0;

        // Both channels of a frame are captured together; a stop skips the latch.
        if (start || wrap) begin
            tx_l_d = IN_L;
            tx_r_d = IN_R;
        end

        if (start || stop) begin
            din_d = 1'b0;
        end else if (fall) begin
            din_d = (p_fall >= 1 && p_fall <= SAMPLE_BITS) ? tx_word[tx_idx] : 1'b0;
        end

        if (rise && p_rise >= 1 && p_rise <= SAMPLE_BITS) begin
            rx_d = {rx_q[SAMPLE_BITS-2:0], dout_q};
            if (p_rise == SAMPLE_BITS) begin
                if (!lrclk) begin
                    hold_d = rx_d;
                end else begin
                    out_l_d   = hold_q;
                    out_r_d   = rx_d;
                    sampled_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_l_q    <= '0;
            tx_r_q    <= '0;
            rx_q      <= '0;
            hold_q    <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            din_q     <= 1'b0;
            dout_q    <= 1'b0;
            sampled_q <= 1'b0;
        end else begin
            tx_l_q    <= tx_l_d;
            tx_r_q    <= tx_r_d;
            rx_q      <= rx_d;
            hold_q    <= hold_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            din_q     <= din_d;
            dout_q    <= i2s_dout;
            sampled_q <= sampled_d;
        end
    end

    assign OUT_L       = out_l_q;
    assign OUT_R       = out_r_q;
    assign i2s_sampled = sampled_q;
    assign i2s_din     = din_q;
    assign i2s_lrclk   = lrclk;

endmodule

// File: tb/tb_i2s_master.sv
// Loopback bench for i2s_master: two instances (default parameters and
// SCLK_DIV=3/SLOT_BITS=24) share stimulus. A frame-level model per instance
// predicts pin waveforms from the cycle count and queues the expected
// received pair and its arrival cycle; a monitor pops on each pulse.
module tb_i2s_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en;
    logic [15:0] in_l, in_r;
    int          checks = 0;
    int          errors = 0;
    int          t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          due;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV   = (g == 0) ? 2 : 3;
        localparam int SLOT  = (g == 0) ? 32 : 24;
        localparam int FRAME = 4 * DIV * SLOT;
        localparam int LAT   = 2 * DIV * (SLOT + 16) + DIV;

        logic [15:0] ol, orr;
        logic        smp, sclk, lrclk;
        wire         loop_w;

        i2s_master #(
            .SCLK_DIV (DIV),
            .SLOT_BITS(SLOT)
        ) dut (
            .CLK        (clk),
            .RESET_N    (rst_n),
            .EN         (en),
            .IN_L       (in_l),
            .IN_R       (in_r),
            .OUT_L      (ol),
            .OUT_R      (orr),
            .i2s_sampled(smp),
            .i2s_sclk   (sclk),
            .i2s_lrclk  (lrclk),
            .i2s_din    (loop_w),
            .i2s_dout   (loop_w)
        );

        exp_t        q[$];
        bit          run = 1'b0;
        int          n = 0;
        int          popped = 0;
        int          seen = 0;
        logic [15:0] cur_l = '0, cur_r = '0, last_l = '0, last_r = '0;

        // Frame-level model: samples at frame starts arrive LAT cycles later.
        always @(posedge clk or negedge rst_n) begin
            exp_t e;
            if (!rst_n) begin
                run = 1'b0;
                n = 0;
                q.delete();
                last_l = '0;
                last_r = '0;
            end else if (!run) begin
                if (en) begin
                    run = 1'b1;
                    n = 0;
                    cur_l = in_l;
                    cur_r = in_r;
                    e = '{l: in_l, r: in_r, due: LAT};
                    q.push_back(e);
                end
            end else begin
                n++;
                if (n % FRAME == 0) begin
                    if (en) begin
                        cur_l = in_l;
                        cur_r = in_r;
                        e = '{l: in_l, r: in_r, due: n + LAT};
                        q.push_back(e);
                    end else begin
                        run = 1'b0;
                    end
                end
            end
        end

        always @(negedge clk) begin
            logic        e_sclk, e_lr, e_din, e_smp;
            logic [15:0] w;
            int          b, p;
            e_sclk = 1'b0;
            e_lr   = 1'b0;
            e_din  = 1'b0;
            if (run) begin
                e_sclk = ((n / DIV) % 2) == 1;
                b      = (n / (2 * DIV)) % (2 * SLOT);
                e_lr   = (b >= SLOT);
                p      = b % SLOT;
                w      = e_lr ? cur_r : cur_l;
                e_din  = (p >= 1 && p <= 16) ? w[16-p] : 1'b0;
            end
            e_smp = run && q.size() > 0 && q[0].due == n;
            chk($sformatf("d%0d sclk n=%0d", g, n), 32'(sclk), 32'(e_sclk));
            chk($sformatf("d%0d lrclk n=%0d", g, n), 32'(lrclk), 32'(e_lr));
            chk($sformatf("d%0d din n=%0d", g, n), 32'(loop_w), 32'(e_din));
            chk($sformatf("d%0d sampled n=%0d", g, n), 32'(smp), 32'(e_smp));
            if (smp) seen++;
            if (e_smp) begin
                last_l = q[0].l;
                last_r = q[0].r;
                void'(q.pop_front());
                popped++;
            end
            chk($sformatf("d%0d out_l n=%0d", g, n), 32'(ol), 32'(last_l));
            chk($sformatf("d%0d out_r n=%0d", g, n), 32'(orr), 32'(last_r));
        end
    end

    // Advance cycles; t indexes the default instance's edges since its start.
    task automatic drive(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #2;
            t++;
            if ((t + 1) % 256 == 0) begin
                if ((t + 1) / 256 == 1) begin
                    in_l = 16'h8000;
                    in_r = 16'h7FFF;
                end else begin
                    in_l = 16'($urandom);
                    in_r = 16'($urandom);
                end
            end else if ((t + 1) % 256 == 128) begin
                in_l = 16'($urandom);
                in_r = 16'($urandom);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " d0 out_l"}, 32'(g_dut[0].ol), 32'd0);
        chk({tag, " d0 out_r"}, 32'(g_dut[0].orr), 32'd0);
        chk({tag, " d0 pins"}, {29'd0, g_dut[0].sclk, g_dut[0].lrclk, g_dut[0].loop_w}, 32'd0);
        chk({tag, " d0 sampled"}, 32'(g_dut[0].smp), 32'd0);
        chk({tag, " d1 out_l"}, 32'(g_dut[1].ol), 32'd0);
        chk({tag, " d1 out_r"}, 32'(g_dut[1].orr), 32'd0);
        chk({tag, " d1 pins"}, {29'd0, g_dut[1].sclk, g_dut[1].lrclk, g_dut[1].loop_w}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        in_l  = '0;
        in_r  = '0;
        t     = -1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        in_l = 16'hA5F0;
        in_r = 16'h0F0F;
        en   = 1'b1;
        t    = -1;
        // Seven default frames, then drop EN while entering b=10.
        drive(6 * 256 + 40);
        en = 1'b0;
        drive(400);
        // Restart from idle.
        en   = 1'b1;
        t    = -1;
        in_l = 16'($urandom);
        in_r = 16'($urandom);
        drive(3 * 256 + 100);
        // Asynchronous reset mid-frame.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid-frame reset");
        in_l = 16'($urandom);
        in_r = 16'($urandom);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        t = -1;
        drive(3 * 256);
        repeat (2) @(negedge clk);
        chk("d0 pulse count", 32'(g_dut[0].seen), 32'(g_dut[0].popped));
        chk("d1 pulse count", 32'(g_dut[1].seen), 32'(g_dut[1].popped));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
